// File: rtl/ex_div_pkg.sv
// Shared CPU definitions for the EX-stage iterative divider:
// state encoding, step count and the conditional two's-complement helper.
package ex_div_pkg;

    localparam int unsigned DIV_W     = 32;
    localparam int unsigned DIV_STEPS = 32;
    localparam int unsigned CNT_W     = 6;

    // Counter value seen in BUSY once every quotient bit has been produced.
    localparam logic [CNT_W-1:0] LAST_CNT = 6'(DIV_STEPS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    function automatic logic [DIV_W-1:0] cond_negate(
        input logic [DIV_W-1:0] val,
        input logic             neg
    );
        if (neg) begin
            cond_negate = ~val + 32'd1;
        end else begin
            cond_negate = val;
        end
    endfunction

endpackage

// File: rtl/ex_div_if.sv
// EX-stage divider handshake: request/operands from the pipeline,
// stall/done/result back from the divider.
interface ex_div_if;
    import ex_div_pkg::*;

    logic             div_start;
    logic             div_signed;
    logic [DIV_W-1:0] div_a;
    logic [DIV_W-1:0] div_b;
    logic             flush;
    logic             div_stall;
    logic             div_done;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_r;

    modport master (
        output div_start, div_signed, div_a, div_b, flush,
        input  div_stall, div_done, div_q, div_r
    );

    modport slave (
        input  div_start, div_signed, div_a, div_b, flush,
        output div_stall, div_done, div_q, div_r
    );

endinterface

// File: rtl/ex_div_step.sv
// One radix-2 restoring division step: shift a dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step
    import ex_div_pkg::*;
(
    input  logic [DIV_W-1:0] rem,
    input  logic [DIV_W-1:0] divisor,
    input  logic             dividend_bit,
    output logic [DIV_W-1:0] rem_next,
    output logic             quot_bit
);

    logic [DIV_W-1:0] shifted_s;
    logic [DIV_W:0]   diff_s;

    assign shifted_s = {rem[DIV_W-2:0], dividend_bit};
    assign diff_s    = {1'b0, shifted_s} - {1'b0, divisor};

    // rem < divisor always holds, so a set rem MSB means the shifted value
    // already exceeds the divisor and the 32-bit difference is exact.
    assign quot_bit = rem[DIV_W-1] | ~diff_s[DIV_W];
    assign rem_next = quot_bit ? diff_s[DIV_W-1:0] : shifted_s;

endmodule

// File: rtl/ex_div.sv
// Multi-cycle DIV/DIVU unit for the EX stage: 32 restoring steps on
// operand magnitudes, sign fix-up on the way into DONE.
module ex_div
    import ex_div_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    ex_div_if.slave bus
);

    div_state_e       state_r;
    div_state_e       next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [DIV_W-1:0] rem_r;
    logic [DIV_W-1:0] dvd_r;
    logic [DIV_W-1:0] dvsr_r;
    logic             q_neg_r;
    logic             r_neg_r;
    logic [DIV_W-1:0] q_r;
    logic [DIV_W-1:0] r_r;
    logic             done_r;

    logic             stall_s;
    logic             accept_s;
    logic             step_s;
    logic             finish_s;
    logic [DIV_W-1:0] step_rem_s;
    logic             step_q_s;
    logic             a_neg_s;
    logic             b_neg_s;

    assign a_neg_s = bus.div_signed & bus.div_a[DIV_W-1];
    assign b_neg_s = bus.div_signed & bus.div_b[DIV_W-1];

    div_step u_step (
        .rem          (rem_r),
        .divisor      (dvsr_r),
        .dividend_bit (dvd_r[DIV_W-1]),
        .rem_next     (step_rem_s),
        .quot_bit     (step_q_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and per-state control strobes.
    always_comb begin
        next_state_s = state_r;
        stall_s      = 1'b0;
        accept_s     = 1'b0;
        step_s       = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.div_start && !bus.flush) begin
                    next_state_s = ST_BUSY;
                    stall_s      = 1'b1;
                    accept_s     = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bus.flush) begin
                    next_state_s = ST_IDLE;
                end else if (cnt_r == LAST_CNT) begin
                    next_state_s = ST_DONE;
                    stall_s      = 1'b1;
                    finish_s     = 1'b1;
                end else begin
                    next_state_s = ST_BUSY;
                    stall_s      = 1'b1;
                    step_s       = 1'b1;
                end
            end
            ST_DONE: begin
                // A still-high div_start belongs to the finishing instruction.
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Operand latch, iteration datapath and registered results.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r   <= 6'd0;
            rem_r   <= 32'd0;
            dvd_r   <= 32'd0;
            dvsr_r  <= 32'd0;
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
            q_r     <= 32'd0;
            r_r     <= 32'd0;
            done_r  <= 1'b0;
        end else begin
            done_r <= finish_s;
            if (accept_s) begin
                cnt_r   <= 6'd0;
                rem_r   <= 32'd0;
                dvd_r   <= cond_negate(bus.div_a, a_neg_s);
                dvsr_r  <= cond_negate(bus.div_b, b_neg_s);
                // Divide-by-zero keeps the all-ones quotient unsigned-looking.
                q_neg_r <= (a_neg_s ^ b_neg_s) & (|bus.div_b);
                r_neg_r <= a_neg_s;
            end else if (step_s) begin
                cnt_r <= cnt_r + 6'd1;
                rem_r <= step_rem_s;
                dvd_r <= {dvd_r[DIV_W-2:0], step_q_s};
            end else if (finish_s) begin
                q_r <= cond_negate(dvd_r, q_neg_r);
                r_r <= cond_negate(rem_r, r_neg_r);
            end
        end
    end

    assign bus.div_stall = stall_s & ~reset;
    assign bus.div_done  = done_r;
    assign bus.div_q     = q_r;
    assign bus.div_r     = r_r;

endmodule
